// File: rtl/phase_seq_monitor.sv
// phase_seq_monitor: watches the phase code of an upstream 4-state sequencer.
// It acquires lock after LOCK_CNT consecutive correct phases (starting at 0),
// then flags sequence errors and, optionally, counts completed 0-1-2-3 laps.
//
// Optional feature macro: PHASE_MON_LAPCNT_EN
//   defined   -> lap_pulse / lap_cnt are live
//   undefined -> lap_pulse / lap_cnt are tied to 0
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   phase_in   phase code, 0..3 legal, 4..7 illegal
//   phase_vld  phase_in is sampled this cycle
//   onehot     registered one-hot decode of the last valid phase (0 for illegal)
//   locked     registered (state == LOCKED)
//   err_pulse  one-cycle pulse per sequence error while locked
//   err_cnt    saturating sequence-error count
//   lap_pulse  one-cycle pulse per completed lap while locked
//   lap_cnt    wrapping lap count
module phase_seq_monitor #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       phase_in,
    input  logic             phase_vld,
    output logic [3:0]       onehot,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic             lap_pulse,
    output logic [7:0]       lap_cnt
);

    localparam int unsigned GOOD_W = 4;
    localparam int unsigned LAP_W  = 8;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        expected_q, expected_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              miss_q, miss_d;
    logic [3:0]        onehot_q, onehot_d;
    logic              locked_q, locked_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic              phase_legal_c;
    logic              phase_hit_c;
    logic [ERR_W-1:0]  err_cnt_inc_c;
    logic [GOOD_W-1:0] good_inc_c;

    // Illegal codes have bit 2 set and therefore never match expected.
    assign phase_legal_c = ~phase_in[2];
    assign phase_hit_c   = (phase_in == {1'b0, expected_q});
    assign good_inc_c    = good_q + GOOD_W'(1);

    // Saturating error increment.
    assign err_cnt_inc_c = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_W'(1);

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        good_d      = good_q;
        miss_d      = miss_q;
        onehot_d    = onehot_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (phase_vld) begin
            onehot_d = phase_legal_c ? (4'b0001 << phase_in[1:0]) : 4'b0000;

            case (state_q)
                UNLOCKED: begin
                    if (phase_in == 3'd0) begin
                        state_d    = ACQUIRE;
                        expected_d = 2'd1;
                        good_d     = GOOD_W'(1);
                    end
                end

                ACQUIRE: begin
                    if (phase_hit_c) begin
                        expected_d = expected_q + 2'd1;
                        good_d     = good_inc_c;
                        if (good_inc_c == GOOD_W'(LOCK_CNT)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        state_d    = UNLOCKED;
                        expected_d = 2'd0;
                        good_d     = '0;
                    end
                end

                LOCKED: begin
                    if (phase_hit_c) begin
                        expected_d = expected_q + 2'd1;
                        miss_d     = 1'b0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_cnt_d   = err_cnt_inc_c;
                        if (!miss_q) begin
                            // First miss: try to resync onto the observed phase.
                            miss_d = 1'b1;
                            if (phase_legal_c) begin
                                expected_d = phase_in[1:0] + 2'd1;
                            end
                        end else begin
                            state_d    = UNLOCKED;
                            miss_d     = 1'b0;
                            good_d     = '0;
                            expected_d = 2'd0;
                        end
                    end
                end

                default: begin
                    state_d    = UNLOCKED;
                    expected_d = 2'd0;
                    good_d     = '0;
                    miss_d     = 1'b0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= UNLOCKED;
            expected_q  <= 2'd0;
            good_q      <= '0;
            miss_q      <= 1'b0;
            onehot_q    <= 4'b0000;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            good_q      <= good_d;
            miss_q      <= miss_d;
            onehot_q    <= onehot_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign onehot    = onehot_q;
    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

`ifdef PHASE_MON_LAPCNT_EN
    logic             lap_hit_c;
    logic             lap_pulse_q, lap_pulse_d;
    logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;

    // A lap completes on a matching phase 3 only once already locked.
    assign lap_hit_c = phase_vld && (state_q == LOCKED) && phase_hit_c
                       && (expected_q == 2'd3);

    // Lap counter next-state.
    always_comb begin
        lap_pulse_d = 1'b0;
        lap_cnt_d   = lap_cnt_q;
        if (lap_hit_c) begin
            lap_pulse_d = 1'b1;
            lap_cnt_d   = lap_cnt_q + LAP_W'(1);
        end
    end

    // Lap registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lap_pulse_q <= 1'b0;
            lap_cnt_q   <= '0;
        end else begin
            lap_pulse_q <= lap_pulse_d;
            lap_cnt_q   <= lap_cnt_d;
        end
    end

    assign lap_pulse = lap_pulse_q;
    assign lap_cnt   = lap_cnt_q;
`else
    assign lap_pulse = 1'b0;
    assign lap_cnt   = LAP_W'(0);
`endif

endmodule

// File: tb/tb_phase_seq_monitor.sv
// Bench for phase_seq_monitor: directed scenarios followed by random phase
// traffic, all compared against a behavioural model. Two instances share the
// stimulus; the second uses ERR_W=2 to exercise error-count saturation.
module tb_phase_seq_monitor;

    localparam int unsigned TB_LOCK = 4;

    localparam int M_UNL = 0;
    localparam int M_ACQ = 1;
    localparam int M_LCK = 2;

    logic       clk;
    logic       rst_n;
    logic [2:0] phase_in;
    logic       phase_vld;

    logic [3:0] onehot_a, onehot_b;
    logic       locked_a, locked_b;
    logic       err_pulse_a, err_pulse_b;
    logic [7:0] err_cnt_a;
    logic [1:0] err_cnt_b;
    logic       lap_pulse_a, lap_pulse_b;
    logic [7:0] lap_cnt_a, lap_cnt_b;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_state, m_exp, m_good, m_errs, m_laps;
    bit m_miss, m_errp, m_lapp;
    int m_onehot;

    phase_seq_monitor #(.LOCK_CNT(TB_LOCK), .ERR_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .phase_in(phase_in), .phase_vld(phase_vld),
        .onehot(onehot_a), .locked(locked_a), .err_pulse(err_pulse_a),
        .err_cnt(err_cnt_a), .lap_pulse(lap_pulse_a), .lap_cnt(lap_cnt_a)
    );

    phase_seq_monitor #(.LOCK_CNT(TB_LOCK), .ERR_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .phase_in(phase_in), .phase_vld(phase_vld),
        .onehot(onehot_b), .locked(locked_b), .err_pulse(err_pulse_b),
        .err_cnt(err_cnt_b), .lap_pulse(lap_pulse_b), .lap_cnt(lap_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle of the specification's rules, written over plain integers.
    task automatic model_step(input bit r, input bit v, input int p);
        bit legal;
        bit hit;
        m_errp = 1'b0;
        m_lapp = 1'b0;
        if (!r) begin
            m_state = M_UNL; m_exp = 0; m_good = 0; m_miss = 1'b0;
            m_onehot = 0; m_errs = 0; m_laps = 0;
        end else if (v) begin
            legal = (p < 4);
            hit   = (p == m_exp);
            m_onehot = legal ? (1 << p) : 0;
            if (m_state == M_UNL) begin
                if (p == 0) begin
                    m_state = M_ACQ; m_exp = 1; m_good = 1;
                end
            end else if (m_state == M_ACQ) begin
                if (hit) begin
                    m_exp  = (m_exp + 1) % 4;
                    m_good = m_good + 1;
                    if (m_good == int'(TB_LOCK)) m_state = M_LCK;
                end else begin
                    m_state = M_UNL; m_good = 0;
                end
            end else begin
                if (hit) begin
                    if (p == 3) begin
                        m_laps++;
                        m_lapp = 1'b1;
                    end
                    m_exp  = (m_exp + 1) % 4;
                    m_miss = 1'b0;
                end else begin
                    m_errp = 1'b1;
                    m_errs++;
                    if (!m_miss) begin
                        m_miss = 1'b1;
                        if (legal) m_exp = (p + 1) % 4;
                    end else begin
                        m_state = M_UNL; m_miss = 1'b0; m_good = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        int exp_lap_cnt;
        bit exp_lap_p;
`ifdef PHASE_MON_LAPCNT_EN
        exp_lap_cnt = m_laps % 256;
        exp_lap_p   = m_lapp;
`else
        exp_lap_cnt = 0;
        exp_lap_p   = 1'b0;
`endif
        check("onehot_a", 32'(onehot_a), 32'(m_onehot));
        check("locked_a", 32'(locked_a), 32'(m_state == M_LCK));
        check("err_pulse_a", 32'(err_pulse_a), 32'(m_errp));
        check("err_cnt_a", 32'(err_cnt_a), 32'((m_errs > 255) ? 255 : m_errs));
        check("lap_pulse_a", 32'(lap_pulse_a), 32'(exp_lap_p));
        check("lap_cnt_a", 32'(lap_cnt_a), 32'(exp_lap_cnt));
        check("onehot_b", 32'(onehot_b), 32'(m_onehot));
        check("locked_b", 32'(locked_b), 32'(m_state == M_LCK));
        check("err_pulse_b", 32'(err_pulse_b), 32'(m_errp));
        check("err_cnt_b", 32'(err_cnt_b), 32'((m_errs > 3) ? 3 : m_errs));
        check("lap_pulse_b", 32'(lap_pulse_b), 32'(exp_lap_p));
        check("lap_cnt_b", 32'(lap_cnt_b), 32'(exp_lap_cnt));
    endtask

    task automatic step(input bit r, input bit v, input int p);
        @(negedge clk);
        rst_n     = r;
        phase_vld = v;
        phase_in  = 3'(p);
        @(posedge clk);
        model_step(r, v, p);
        #1;
        compare_all();
    endtask

    initial begin
        int seq;
        int exp_laps2;
        bit r;
        bit v;
        int p;

        rst_n     = 1'b0;
        phase_vld = 1'b0;
        phase_in  = 3'd0;

        // Reset, including reset winning over a valid sample.
        step(0, 0, 0);
        step(0, 1, 3);
        check("rst_locked", 32'(locked_a), 32'd0);
        check("rst_onehot", 32'(onehot_a), 32'd0);
        check("rst_err_cnt", 32'(err_cnt_a), 32'd0);

        // Acquire: 0,1,2,3 -> locked on the cycle after phase 3.
        step(1, 1, 0);
        step(1, 1, 1);
        step(1, 0, 1);
        step(1, 1, 2);
        check("pre_lock", 32'(locked_a), 32'd0);
        step(1, 1, 3);
        check("lock_after_p3", 32'(locked_a), 32'd1);
        check("no_lap_in_acq", 32'(lap_cnt_a), 32'd0);

        // Two laps while locked.
        for (int i = 0; i < 8; i++) begin
            step(1, 1, i % 4);
            if (i == 3) step(1, 0, 7);
        end
`ifdef PHASE_MON_LAPCNT_EN
        exp_laps2 = 2;
`else
        exp_laps2 = 0;
`endif
        check("two_laps", 32'(lap_cnt_a), 32'(exp_laps2));
        check("no_err_laps", 32'(err_cnt_a), 32'd0);

        // Resync: expected 2, send 0 then 1, then 2.
        step(1, 1, 0);
        step(1, 1, 1);
        step(1, 1, 0);
        check("resync_err", 32'(err_pulse_a), 32'd1);
        step(1, 1, 1);
        check("resync_no_err", 32'(err_pulse_a), 32'd0);
        check("resync_locked", 32'(locked_a), 32'd1);
        step(1, 1, 2);
        check("resync_cnt", 32'(err_cnt_a), 32'd1);

        // Illegal codes: 5 then 7 -> unlock.
        step(1, 1, 5);
        check("illegal1_locked", 32'(locked_a), 32'd1);
        step(1, 1, 7);
        check("illegal2_unlock", 32'(locked_a), 32'd0);
        check("illegal_onehot", 32'(onehot_a), 32'd0);
        check("illegal_err_cnt", 32'(err_cnt_a), 32'd3);

        // Saturation of the 2-bit counter.
        for (int i = 0; i < 4; i++) step(1, 1, i);
        step(1, 1, 7);
        step(1, 1, 6);
        check("sat_w8", 32'(err_cnt_a), 32'd5);
        check("sat_w2", 32'(err_cnt_b), 32'd3);

        // Reset mid-acquire with a valid sample present.
        step(1, 1, 0);
        step(1, 1, 1);
        step(0, 1, 2);
        check("mid_acq_locked", 32'(locked_a), 32'd0);
        check("mid_acq_onehot", 32'(onehot_a), 32'd0);
        check("mid_acq_err", 32'(err_cnt_a), 32'd0);
        check("mid_acq_lap", 32'(lap_cnt_a), 32'd0);

        // Random traffic: mostly an ideal sequencer with injected faults.
        seq = 0;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 199) != 0);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) < 14) begin
                p = seq;
                if (v) seq = (seq + 1) % 4;
            end else begin
                p = int'($urandom_range(0, 7));
            end
            step(r, v, p);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
